// File: rtl/count_step_decoder.sv
// Observation-side decoder for the up/down step counter: recovers step size and direction
// from consecutive samples, flags illegal deltas and locks on a steady mode. COUNT_DEC_HOLD_EN makes delta 0 a legal hold.
module count_step_decoder #(
    parameter int WIDTH  = 4,
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] cnt,
    output logic             dec_valid,
    output logic             step,
    output logic             down,
    output logic             hold,
    output logic             err,
    output logic             mode_chg,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] D_UP1   = WIDTH'(1);
    localparam logic [WIDTH-1:0] D_UP2   = WIDTH'(2);
    localparam logic [WIDTH-1:0] D_DOWN1 = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] D_DOWN2 = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [3:0]       LOCK_NV = 4'(LOCK_N);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [3:0]       run_cnt;
    logic             mode_step;
    logic             mode_down;

    logic [WIDTH-1:0] delta;
    logic             is_move;
    logic             is_hold;
    logic             dec_step;
    logic             dec_down;
    logic             same_mode;
    logic [3:0]       run_next;

    // Modular subtraction makes wrap-around (e.g. 15 -> 0) decode as an ordinary step.
    assign delta     = cnt - prev;
    assign is_move   = (delta == D_UP1) || (delta == D_UP2) ||
                       (delta == D_DOWN1) || (delta == D_DOWN2);
    assign dec_step  = (delta == D_UP2) || (delta == D_DOWN2);
    assign dec_down  = (delta == D_DOWN1) || (delta == D_DOWN2);
    assign same_mode = (dec_step == mode_step) && (dec_down == mode_down);
    assign run_next  = same_mode ? run_cnt + 4'd1 : 4'd1;
    assign locked    = (state == LOCKED);

`ifdef COUNT_DEC_HOLD_EN
    logic hold_q;
    assign is_hold = (delta == '0);
    assign hold    = hold_q;
`else
    assign is_hold = 1'b0;
    assign hold    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            prev      <= '0;
            run_cnt   <= '0;
            mode_step <= 1'b0;
            mode_down <= 1'b0;
            dec_valid <= 1'b0;
            step      <= 1'b0;
            down      <= 1'b0;
            err       <= 1'b0;
            mode_chg  <= 1'b0;
            err_count <= '0;
`ifdef COUNT_DEC_HOLD_EN
            hold_q    <= 1'b0;
`endif
        end else begin
            dec_valid <= 1'b0;
            err       <= 1'b0;
            mode_chg  <= 1'b0;
            if (in_valid) begin
                // prev follows every sample, even illegal ones, so decoding resynchronises.
                prev <= cnt;
                if (state == EMPTY) begin
                    state <= TRACK;
                end else if (is_move) begin
                    dec_valid <= 1'b1;
                    step      <= dec_step;
                    down      <= dec_down;
`ifdef COUNT_DEC_HOLD_EN
                    hold_q    <= 1'b0;
`endif
                    if (state == LOCKED) begin
                        if (!same_mode) begin
                            mode_chg  <= 1'b1;
                            state     <= TRACK;
                            run_cnt   <= 4'd1;
                            mode_step <= dec_step;
                            mode_down <= dec_down;
                        end
                    end else begin
                        run_cnt   <= run_next;
                        mode_step <= dec_step;
                        mode_down <= dec_down;
                        if (run_next >= LOCK_NV) state <= LOCKED;
                    end
                end else if (is_hold) begin
                    dec_valid <= 1'b1;
`ifdef COUNT_DEC_HOLD_EN
                    hold_q    <= 1'b1;
`endif
                end else begin
                    err     <= 1'b1;
                    run_cnt <= '0;
                    state   <= TRACK;
                    if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
                end
            end
        end
    end

endmodule
